// File: rtl/alu_pkg.sv
// Shared encodings for the ALU request/response unit.
// Used by the ALU responder and the stimulus driver.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SLL = 2'b01,
    OP_AND = 2'b10,
    OP_SRA = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_HOLD = 2'b10
  } alu_state_e;

  function automatic logic is_shift(input alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shift of the serial accumulator.
// SLL fills the LSB with zero, SRA replicates the MSB.
module alu_shift_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic             sra_i,
  output logic [WIDTH-1:0] acc_o
);

  assign acc_o = sra_i ? {acc_i[WIDTH-1], acc_i[WIDTH-1:1]}
                       : {acc_i[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/alu_resp_unit.sv
// ALU responder: valid/ready request in, valid/ready result out.
// ADD/AND finish in one cycle; shifts run one bit per cycle.
module alu_resp_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_zero,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  alu_state_e         state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               sra_q, sra_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               zero_q, zero_d;
  logic [CNT_W-1:0]   ops_q, ops_d;
  logic [WIDTH-1:0]   acc_step;
  alu_op_e            op;

  assign op = alu_op_e'(req_op);

  alu_shift_step #(.WIDTH(WIDTH)) u_step (
    .acc_i (acc_q),
    .sra_i (sra_q),
    .acc_o (acc_step)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sra_d   = sra_q;
    tag_d   = tag_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ops_d   = ops_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          tag_d = req_tag;
          sra_d = (op == OP_SRA);
          if (is_shift(op)) begin
            acc_d   = req_a;
            cnt_d   = req_b[SHAMT_W-1:0];
            state_d = S_BUSY;
          end else begin
            res_d   = (op == OP_ADD) ? req_a + req_b
                                     : req_a & req_b;
            zero_d  = (res_d == '0);
            state_d = S_HOLD;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          res_d   = acc_q;
          zero_d  = (acc_q == '0);
          state_d = S_HOLD;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (rsp_ready) begin
          ops_d   = ops_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sra_q   <= 1'b0;
      tag_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sra_q   <= sra_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ops_q   <= ops_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_HOLD);
  assign busy       = (state_q != S_IDLE);
  assign rsp_result = res_q;
  assign rsp_tag    = tag_q;
  assign rsp_zero   = zero_q;
  assign ops_done   = ops_q;

endmodule

// File: tb/tb_alu_resp_unit.sv
// Bench for alu_resp_unit: directed table, random ops vs a
// behavioural model, response stall and mid-shift reset.
module tb_alu_resp_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [1:0]  req_op;
  logic [3:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        rsp_zero;
  logic        busy;
  logic [15:0] ops_done;

  int checks = 0;
  int errors = 0;
  int ops_exp = 0;

  always #5 clk = ~clk;

  alu_resp_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_tag    (req_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
    .rsp_zero   (rsp_zero),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [3:0]  tag;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [31:0] a,
      input logic [31:0] b, input logic [1:0] op);
    int sh;
    sh = int'(b % 32);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a << sh;
      2'b10:   return a & b;
      default: return $unsigned($signed(a) >>> sh);
    endcase
  endfunction

  function automatic int model_lat(input logic [31:0] b,
                                   input logic [1:0] op);
    if (op == 2'b01 || op == 2'b11) return int'(b % 32) + 2;
    return 1;
  endfunction

  // All stimulus changes happen 1 time unit after a rising edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic [3:0] tag,
                       input logic [31:0] res, input int lat,
                       input int stall, input string name);
    int n;
    logic [31:0] r0;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_tag   = tag;
    req_valid = 1'b1;
    rsp_ready = (stall == 0);
    chk({name, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, ".lat"}, 32'(n), 32'(lat));
    chk({name, ".res"}, rsp_result, res);
    chk({name, ".tag"}, 32'(rsp_tag), 32'(tag));
    chk({name, ".zero"}, 32'(rsp_zero), 32'(res == 0));
    r0 = rsp_result;
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'b1;
      req_a     = $urandom;
      req_b     = $urandom;
      req_op    = 2'($urandom);
      req_tag   = 4'($urandom);
      @(posedge clk); #1;
      chk({name, ".hold_v"}, 32'(rsp_valid), 32'd1);
      chk({name, ".hold_res"}, rsp_result, r0);
      chk({name, ".hold_tag"}, 32'(rsp_tag), 32'(tag));
      chk({name, ".hold_rdy"}, 32'(req_ready), 32'd0);
      chk({name, ".hold_ops"}, 32'(ops_done), 32'(ops_exp));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    ops_exp = (ops_exp + 1) % 65536;
    chk({name, ".ops"}, 32'(ops_done), 32'(ops_exp));
    chk({name, ".idle_v"}, 32'(rsp_valid), 32'd0);
    chk({name, ".idle_rdy"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [1:0]  op;
    vecs[0] = '{32'd50, 32'd100, 2'b00, 4'd3, 32'd150, 1};
    vecs[1] = '{32'd1, 32'd3, 2'b01, 4'd5, 32'd8, 5};
    vecs[2] = '{32'd11, 32'd5, 2'b10, 4'd6, 32'd1, 1};
    vecs[3] = '{32'h8000_0000, 32'd4, 2'b11, 4'd7,
                32'hF800_0000, 6};
    vecs[4] = '{32'd10, 32'd5, 2'b11, 4'd8, 32'd0, 7};
    vecs[5] = '{32'h1234_5678, 32'd0, 2'b11, 4'd9,
                32'h1234_5678, 2};
    vecs[6] = '{32'hFFFF_FFFF, 32'd1, 2'b00, 4'd10, 32'd0, 1};
    vecs[7] = '{32'd3, 32'hFFFF_FFE2, 2'b01, 4'd11, 32'd12, 4};

    rst = 1'b1;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    req_tag = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.result", rsp_result, 32'd0);
    chk("rst.tag", 32'(rsp_tag), 32'd0);
    chk("rst.zero", 32'(rsp_zero), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.ops", 32'(ops_done), 32'd0);
    chk("rst.req_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag,
            vecs[i].res, vecs[i].lat, 0, $sformatf("vec%0d", i));

    do_op(32'd7, 32'd9, 2'b00, 4'd12, 32'd16, 1, 5, "stall_add");
    do_op(32'h0F0F_0000, 32'd2, 2'b11, 4'd13, 32'h03C3_C000, 4, 3,
          "stall_sra");

    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      b  = $urandom;
      op = 2'($urandom);
      if (i % 8 == 0) a = 32'h8000_0000 | a;
      do_op(a, b, op, 4'(i), model_res(a, b, op), model_lat(b, op),
            int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a long shift.
    req_a = 32'd1;
    req_b = 32'd31;
    req_op = 2'b01;
    req_tag = 4'd14;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid.busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ops_exp = 0;
    chk("mid.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid.result", rsp_result, 32'd0);
    chk("mid.tag", 32'(rsp_tag), 32'd0);
    chk("mid.zero", 32'(rsp_zero), 32'd0);
    chk("mid.busy0", 32'(busy), 32'd0);
    chk("mid.ops", 32'(ops_done), 32'd0);
    chk("mid.req_ready", 32'(req_ready), 32'd1);
    do_op(32'd2, 32'd2, 2'b00, 4'd1, 32'd4, 1, 0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
